// File: rtl/cnt20_pkg.sv
// cnt20_pkg: shared state type, counter range constants and a range clamp
// for the cnt20 run-control sequencer.
`timescale 1ns/1ps
`default_nettype none

package cnt20_pkg;

  localparam int CNT20_W = 5;
  localparam logic [CNT20_W-1:0] CNT20_MAX = CNT20_W'(19);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    END   = 2'd3
  } cnt20_state_t;

  // Out-of-range counter values are handled as if they were the top value.
  function automatic logic [CNT20_W-1:0] cnt20_clamp(input logic [CNT20_W-1:0] v);
    return (v > CNT20_MAX) ? CNT20_MAX : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchronizer, stability counter, debounced level and
// one-cycle rising-edge event for a single raw switch.
`timescale 1ns/1ps
`default_nettype none

module sw_debounce #(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          rise_q;

  // The level flips on the edge where the synchronized value has already
  // disagreed for DB_CYCLES edges, so one extra edge completes the run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw_i};
      rise_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == C_LAST) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        rise_q  <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

`default_nettype wire

// File: rtl/cnt20_seq_ctrl.sv
// cnt20_seq_ctrl: switch debouncing, step prescaler and run-control FSM for
// the 0..19 counter. Define CNT20_AUTOSTOP_EN to enable end-stop handling.
`timescale 1ns/1ps
`default_nettype none

module cnt20_seq_ctrl
  import cnt20_pkg::*;
#(
  parameter int DIV       = 50_000_000,
  parameter int DB_CYCLES = 500_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sw_start,
  input  logic               sw_ud,
  input  logic               sw_clr,
  input  logic [CNT20_W-1:0] count,
  output logic               cnt_en,
  output logic               cnt_ud,
  output logic               cnt_clr,
  output logic               running
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  logic w_start_ev, w_clr_ev, w_ud_lvl;
  logic w_start_lvl_unused, w_clr_lvl_unused, w_ud_rise_unused;

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clock(clock), .reset(reset), .sw_i(sw_start),
    .level_o(w_start_lvl_unused), .rise_o(w_start_ev)
  );

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ud (
    .clock(clock), .reset(reset), .sw_i(sw_ud),
    .level_o(w_ud_lvl), .rise_o(w_ud_rise_unused)
  );

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clock(clock), .reset(reset), .sw_i(sw_clr),
    .level_o(w_clr_lvl_unused), .rise_o(w_clr_ev)
  );

  cnt20_state_t  state_q, state_d;
  logic [PW-1:0] presc_q;
  logic          en_q, en_d;
  logic          clr_q, clr_d;
  logic          ud_q, ud_d;
  logic          run_q;
  logic          w_tick;

  assign w_tick = (state_q == RUN) && (presc_q == P_LAST);

`ifdef CNT20_AUTOSTOP_EN
  logic               end_up_q, end_up_d;
  logic [CNT20_W-1:0] w_cnt;
  logic               w_at_end;

  assign w_cnt    = cnt20_clamp(count);
  assign w_at_end = (ud_q && (w_cnt == CNT20_MAX)) || (!ud_q && (w_cnt == '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) end_up_q <= 1'b1;
    else       end_up_q <= end_up_d;
  end
`else
  logic w_count_unused;
  assign w_count_unused = ^count;
`endif

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    clr_d   = 1'b0;
`ifdef CNT20_AUTOSTOP_EN
    end_up_d = end_up_q;
`endif
    if (w_clr_ev) begin
      state_d = IDLE;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE, PAUSE: if (w_start_ev) state_d = RUN;
        RUN: begin
          if (w_tick) begin
`ifdef CNT20_AUTOSTOP_EN
            if (w_at_end) begin
              state_d  = END;
              end_up_d = ud_q;
            end else begin
              en_d = 1'b1;
              if (w_start_ev) state_d = PAUSE;
            end
`else
            en_d = 1'b1;
            if (w_start_ev) state_d = PAUSE;
`endif
          end else if (w_start_ev) begin
            state_d = PAUSE;
          end
        end
`ifdef CNT20_AUTOSTOP_EN
        END: if (w_start_ev && (ud_q != end_up_q)) state_d = RUN;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Direction only moves on a step boundary while running.
  assign ud_d = ((state_q != RUN) || w_tick) ? w_ud_lvl : ud_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      ud_q    <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == RUN) && (state_d == RUN))
        presc_q <= (presc_q == P_LAST) ? '0 : presc_q + 1'b1;
      else
        presc_q <= '0;
      en_q  <= en_d;
      clr_q <= clr_d;
      ud_q  <= ud_d;
      run_q <= (state_d == RUN);
    end
  end

  assign cnt_en  = en_q;
  assign cnt_clr = clr_q;
  assign cnt_ud  = ud_q;
  assign running = run_q;

endmodule

`default_nettype wire

// File: tb/tb_cnt20_seq_ctrl.sv
// tb_cnt20_seq_ctrl: directed scenarios plus randomized switch activity,
// checked every cycle against a window-based behavioural model.
`timescale 1ns/1ps
`default_nettype none

module tb_cnt20_seq_ctrl;

  localparam int DIV = 4;
  localparam int DB  = 3;
`ifdef CNT20_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sw_start = 1'b0, sw_ud = 1'b0, sw_clr = 1'b0;
  logic [4:0] count = 5'd0;
  logic       cnt_en, cnt_ud, cnt_clr, running;

  cnt20_seq_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .clock(clock), .reset(reset), .sw_start(sw_start), .sw_ud(sw_ud),
    .sw_clr(sw_clr), .count(count), .cnt_en(cnt_en), .cnt_ud(cnt_ud),
    .cnt_clr(cnt_clr), .running(running)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: switch acceptance by a sliding window of raw samples,
  // steps by elapsed edges since entering RUN.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_END} mstate_t;
  mstate_t m_st;
  int      m_entry;
  bit      m_ud, m_en, m_clr, m_run, m_end_up;
  bit      lvl [3];
  bit      ev  [3];
  bit      hist[3][DB+3];

  function automatic void model_reset();
    m_st = M_IDLE; m_entry = 0; m_ud = 1'b1; m_en = 1'b0; m_clr = 1'b0;
    m_run = 1'b0; m_end_up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lvl[i] = 1'b0; ev[i] = 1'b0;
      for (int j = 0; j < DB + 3; j++) hist[i][j] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    bit tick, se, ce, at_end, all_diff;
    int c;
    mstate_t ns;
    bit sw[3];
    sw[0] = sw_start; sw[1] = sw_ud; sw[2] = sw_clr;
    se = ev[0]; ce = ev[2];
    tick = (m_st == M_RUN) && (((cyc - m_entry) % DIV) == 0);
    c = (count > 19) ? 19 : int'(count);
    at_end = AUTOSTOP && ((m_ud && c == 19) || (!m_ud && c == 0));
    ns = m_st; m_en = 1'b0; m_clr = 1'b0;
    if (ce) begin
      ns = M_IDLE; m_clr = 1'b1;
    end else if (tick) begin
      if (at_end) begin
        ns = M_END; m_end_up = m_ud;
      end else begin
        m_en = 1'b1;
        if (se) ns = M_PAUSE;
      end
    end else if (se) begin
      case (m_st)
        M_RUN:   ns = M_PAUSE;
        M_END:   if (m_ud != m_end_up) ns = M_RUN;
        default: ns = M_RUN;
      endcase
    end
    if (m_st != M_RUN || tick) m_ud = lvl[1];
    if (ns == M_RUN && m_st != M_RUN) m_entry = cyc;
    m_st = ns;
    m_run = (ns == M_RUN);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < DB + 2; j++) hist[i][j] = hist[i][j+1];
      hist[i][DB+2] = sw[i];
      all_diff = 1'b1;
      for (int j = 0; j <= DB; j++) if (hist[i][j] == lvl[i]) all_diff = 1'b0;
      ev[i] = 1'b0;
      if (all_diff) begin
        lvl[i] = ~lvl[i];
        ev[i]  = lvl[i];
      end
    end
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (reset) model_reset();
    else       model_step();
  end

  task automatic cycle_chk();
    @(negedge clock);
    check_eq("cnt_en",  cnt_en,  m_en);
    check_eq("cnt_clr", cnt_clr, m_clr);
    check_eq("cnt_ud",  cnt_ud,  m_ud);
    check_eq("running", running, m_run);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle_chk();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) cycle_chk();
  endtask

  int  e, n, waited;
  int  hold[3];
  bit  seen;

  initial begin
    model_reset();
    // Reset values, including cnt_ud high while sw_ud is low.
    repeat (3) @(negedge clock);
    check_eq("rst_en",  cnt_en,  0);
    check_eq("rst_clr", cnt_clr, 0);
    check_eq("rst_ud",  cnt_ud,  1);
    check_eq("rst_run", running, 0);
    reset = 1'b0;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 6) begin
      cycle_chk();
      waited++;
      if (cnt_ud == 1'b0) seen = 1'b1;
    end
    check_eq("ud_after_rst", seen, 1);

    // Start and step rate.
    sw_ud = 1'b1; count = 5'd5;
    cycles(10);
    sw_start = 1'b1; e = cyc + 1;
    run_to(e + 5);
    check_eq("run_early", running, 0);
    run_to(e + 6);
    check_eq("run_at_6", running, 1);
    for (int i = 1; i <= 12; i++) begin
      cycle_chk();
      check_eq($sformatf("step_%0d", i), cnt_en, ((i % 4) == 0) ? 1 : 0);
    end

    // Clear accepted on the same cycle as a tick (tick edge at e+6+20).
    n = e + 6 + 20 - 6;
    run_to(n - 1);
    sw_clr = 1'b1;
    run_to(n + 6);
    check_eq("clr_pri_clr", cnt_clr, 1);
    check_eq("clr_pri_en",  cnt_en,  0);
    check_eq("clr_pri_run", running, 0);
    sw_clr = 1'b0; sw_start = 1'b0;
    cycles(10);

    // Glitch rejection.
    sw_start = 1'b1; cycles(2); sw_start = 1'b0;
    cycles(12);
    check_eq("glitch_run", running, 0);

    // Pause and resume.
    sw_start = 1'b1; cycles(10);
    sw_start = 1'b0; cycles(8);
    sw_start = 1'b1; e = cyc + 1;
    run_to(e + 6);
    check_eq("paused_run", running, 0);
    for (int i = 0; i < 10; i++) begin
      cycle_chk();
      check_eq("pause_no_step", cnt_en, 0);
    end
    sw_start = 1'b0; cycles(8);
    sw_start = 1'b1; e = cyc + 1;
    run_to(e + 6);
    check_eq("resume_run", running, 1);
    for (int i = 1; i <= 4; i++) begin
      cycle_chk();
      check_eq($sformatf("resume_step_%0d", i), cnt_en, (i == 4) ? 1 : 0);
    end

    // End-stop at 19 going up.
    sw_clr = 1'b1; cycles(8); sw_clr = 1'b0; sw_start = 1'b0;
    count = 5'd19; sw_ud = 1'b1; cycles(8);
    sw_start = 1'b1; e = cyc + 1;
    run_to(e + 10);
    check_eq("end_tick_en",  cnt_en,  AUTOSTOP ? 0 : 1);
    check_eq("end_tick_run", running, AUTOSTOP ? 0 : 1);
`ifdef CNT20_AUTOSTOP_EN
    sw_start = 1'b0; cycles(8);
    sw_start = 1'b1; e = cyc + 1;
    run_to(e + 8);
    check_eq("end_hold_run", running, 0);
    sw_ud = 1'b0; sw_start = 1'b0; cycles(8);
    sw_start = 1'b1; e = cyc + 1;
    run_to(e + 6);
    check_eq("end_leave_run", running, 1);
    run_to(e + 10);
    check_eq("down_step_en", cnt_en, 1);
    check_eq("down_step_ud", cnt_ud, 0);
`endif
    sw_clr = 1'b1; cycles(8); sw_clr = 1'b0;

    // Randomized switch activity, count values and occasional resets.
    for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, 12);
    for (int k = 0; k < 2500; k++) begin
      cycle_chk();
      for (int i = 0; i < 3; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          hold[i] = (i == 2) ? $urandom_range(1, 40) : $urandom_range(1, 14);
          case (i)
            0: sw_start = ~sw_start;
            1: sw_ud    = ~sw_ud;
            default: sw_clr = ($urandom_range(0, 2) == 0) ? ~sw_clr : 1'b0;
          endcase
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: count = 5'd19;
          1: count = 5'd0;
          default: count = 5'($urandom_range(0, 31));
        endcase
      end
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 799) == 0) reset = 1'b1;
    end
    reset = 1'b0;
    cycles(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
